// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants, FSM state type and width helper for the
//               FIR sample feeder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

  localparam int FIR_DW           = 12;
  localparam int FIR_ISSUE_PERIOD = 8;

  typedef enum logic [0:0] {
    FEED_IDLE = 1'b0,
    FEED_GAP  = 1'b1
  } feed_state_t;

  // Ceiling log2, usable in constant expressions for port and counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_sample_feeder_if.sv
// ============================================================================
// Module      : fir_sample_feeder_if
// Description : Upstream sample stream (valid/ready/data) into the feeder.
//               master : sample producer (drives s_valid, s_data)
//               slave  : feeder          (drives s_ready)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fir_sample_feeder_if
  import fir_pkg::*;
#(
  parameter int DW = FIR_DW
);

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

`default_nettype wire

// File: rtl/fir_sync_fifo.sv
// ============================================================================
// Module      : fir_sync_fifo
// Description : Single-clock FIFO with registered occupancy and the head
//               entry presented combinationally on o_rdata.
// Ports       : clk, rst_n (async active-low)
//               i_push/i_wdata  write side (ignored when full)
//               i_pop/o_rdata   read side (ignored when empty)
//               o_level, o_full, o_empty  occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int DEPTH = 8
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        i_push,
  input  wire logic                        i_pop,
  input  wire logic [DW-1:0]               i_wdata,
  output logic      [DW-1:0]               o_rdata,
  output logic      [clog2(DEPTH+1)-1:0]   o_level,
  output logic                             o_full,
  output logic                             o_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop  && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_sample_feeder.sv
// ============================================================================
// Module      : fir_sample_feeder
// Description : Buffers upstream samples and issues them to the serial FIR
//               as one-cycle en/xin strobes spaced at least ISSUE_PERIOD
//               cycles apart, so each lands on FIR phase 0.
// Ports       : clk, rst_n      clock, async active-low reset
//               s_if (slave)    upstream valid/ready/data stream
//               o_fir_en        one-cycle issue strobe (registered)
//               o_fir_xin       issued sample, valid while o_fir_en=1
//               o_level         FIFO occupancy
//               o_underrun      zero-fill slot pulse
// Options     : FIR_FEEDER_ZERO_FILL_EN - once started, every empty issue
//               slot sends a zero sample and pulses o_underrun, keeping the
//               FIR rate constant. Undefined: o_underrun is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DW           = FIR_DW,
  parameter int DEPTH        = 8,
  parameter int ISSUE_PERIOD = FIR_ISSUE_PERIOD
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  fir_sample_feeder_if.slave             s_if,
  output logic                           o_fir_en,
  output logic [DW-1:0]                  o_fir_xin,
  output logic [clog2(DEPTH+1)-1:0]      o_level,
  output logic                           o_underrun
);

  localparam int CW = clog2(ISSUE_PERIOD);

  feed_state_t   r_state;
  feed_state_t   w_state_nxt;
  logic [CW-1:0] r_gap_cnt;
  logic [CW-1:0] w_gap_nxt;
  logic          r_fir_en;
  logic [DW-1:0] r_fir_xin;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_full;
  logic          w_empty;
  logic [DW-1:0] w_head;
`ifdef FIR_FEEDER_ZERO_FILL_EN
  logic          w_fill;
  logic          r_underrun;
`endif

  // Ready depends only on the registered level: a pop in the same cycle
  // does not open a slot for a push into a full FIFO.
  assign s_if.s_ready = !w_full;
  assign w_push       = s_if.s_valid && !w_full;

  fir_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (s_if.s_data),
    .o_rdata (w_head),
    .o_level (o_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The gap counter is loaded with ISSUE_PERIOD-1 on an issue and counts
  // down once per cycle; the edge that sees it at zero is the next issue
  // slot, giving exactly ISSUE_PERIOD cycles between strobes on a backlog.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
`ifdef FIR_FEEDER_ZERO_FILL_EN
    w_fill      = 1'b0;
`endif
    case (r_state)
      FEED_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_issue     = 1'b1;
          w_gap_nxt   = CW'(ISSUE_PERIOD - 1);
          w_state_nxt = FEED_GAP;
        end
      end
      FEED_GAP: begin
        if (r_gap_cnt != '0) begin
          w_gap_nxt = r_gap_cnt - CW'(1);
        end else if (!w_empty) begin
          w_pop     = 1'b1;
          w_issue   = 1'b1;
          w_gap_nxt = CW'(ISSUE_PERIOD - 1);
        end else begin
`ifdef FIR_FEEDER_ZERO_FILL_EN
          w_fill    = 1'b1;
          w_issue   = 1'b1;
          w_gap_nxt = CW'(ISSUE_PERIOD - 1);
`else
          w_state_nxt = FEED_IDLE;
`endif
        end
      end
      default: w_state_nxt = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FEED_IDLE;
      r_gap_cnt <= '0;
      r_fir_en  <= 1'b0;
      r_fir_xin <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_fir_en  <= w_issue;
      if (w_pop) begin
        r_fir_xin <= w_head;
      end
`ifdef FIR_FEEDER_ZERO_FILL_EN
      else if (w_fill) begin
        r_fir_xin <= '0;
      end
`endif
    end
  end

`ifdef FIR_FEEDER_ZERO_FILL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_underrun <= 1'b0;
    else        r_underrun <= w_fill;
  end
  assign o_underrun = r_underrun;
`else
  assign o_underrun = 1'b0;
`endif

  assign o_fir_en  = r_fir_en;
  assign o_fir_xin = r_fir_xin;

endmodule

`default_nettype wire

// File: tb/tb_fir_sample_feeder.sv
// ============================================================================
// Module      : tb_fir_sample_feeder
// Description : Directed-vector scoreboard bench for fir_sample_feeder.
//               Stimulus queues expected {sample, issue edge}; a negedge
//               monitor pops and compares on every fir_en strobe.
// Options     : honours FIR_FEEDER_ZERO_FILL_EN for the expected schedule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_sample_feeder;
  import fir_pkg::*;

  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int P     = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          fir_en;
  logic [DW-1:0] fir_xin;
  logic [3:0]    level;
  logic          underrun;

  fir_sample_feeder_if #(.DW(DW)) s_if ();

  fir_sample_feeder #(
    .DW           (DW),
    .DEPTH        (DEPTH),
    .ISSUE_PERIOD (P)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_if       (s_if),
    .o_fir_en   (fir_en),
    .o_fir_xin  (fir_xin),
    .o_level    (level),
    .o_underrun (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int ecyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_en  = -1000;
  int   n_under  = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && fir_en) begin
      n_checks++;
      if (cyc - last_en < P) begin
        n_errors++;
        $display("FAIL issue_spacing actual=%0d expected>=%0d", cyc - last_en, P);
      end
      last_en = cyc;
      if (underrun) begin
        n_under++;
`ifdef FIR_FEEDER_ZERO_FILL_EN
        chk("fill_xin", 32'(fir_xin), 0);
`else
        chk("underrun_tied_low", 32'(underrun), 0);
`endif
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_issue actual xin=%0d edge=%0d expected none", fir_xin, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("fir_xin", 32'(fir_xin), mon_e.data);
        if (mon_e.ecyc >= 0) chk("issue_edge", cyc, mon_e.ecyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int d, output int pe);
    s_if.s_valid = 1'b1;
    s_if.s_data  = DW'(d);
    pe = cyc + 1;
    tick();
    s_if.s_valid = 1'b0;
  endtask

  task automatic expect_issue(input int d, input int e);
    exp_t x;
    x.data = d;
    x.ecyc = e;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    last_en = -1000;
    tick();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pe, pe2, e0, e, u0, waited;
    logic rdy;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    rst_n        = 1'b0;
    #2;
    chk("reset_fir_en", 32'(fir_en), 0);
    chk("reset_fir_xin", 32'(fir_xin), 0);
    chk("reset_level", 32'(level), 0);
    chk("reset_s_ready", 32'(s_if.s_ready), 1);
    chk("reset_underrun", 32'(underrun), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: idle after reset
    repeat (50) begin
      @(negedge clk);
      chk("idle_fir_en", 32'(fir_en), 0);
      chk("idle_s_ready", 32'(s_if.s_ready), 1);
      chk("idle_level", 32'(level), 0);
    end
    tick();

    // 2: three consecutive pushes
    do_reset();
    e0 = cyc + 1;
    expect_issue(100, e0 + 1);
    expect_issue(200, e0 + 9);
    expect_issue(300, e0 + 17);
    push1(100, pe);
    push1(200, pe);
    push1(300, pe);
    drain(60);
    repeat (20) tick();

    // 3: sustained stream of 1..20 with back-pressure
    do_reset();
    e0 = cyc + 1;
    for (int i = 1; i <= 20; i++) expect_issue(i, e0 + 1 + P * (i - 1));
    for (int i = 1; i <= 20; i++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = DW'(i);
      waited = 0;
      forever begin
        @(negedge clk);
        if (cyc == e0 + 7) begin
          chk("stream_level_e7", 32'(level), 7);
          chk("stream_ready_e7", 32'(s_if.s_ready), 1);
        end
        if (cyc == e0 + 8) begin
          chk("stream_level_full", 32'(level), 8);
          chk("stream_ready_full", 32'(s_if.s_ready), 0);
        end
        rdy = s_if.s_ready;
        tick();
        waited++;
        if (rdy || waited > 50) break;
      end
      if (!rdy) begin
        n_checks++;
        n_errors++;
        $display("FAIL stream_push_timeout actual=stalled expected=accepted sample %0d", i);
      end
    end
    s_if.s_valid = 1'b0;
    drain(250);

    // 6: sample arrives exactly on an empty GAP issue slot
    do_reset();
    expect_issue(5, cyc + 2);
    push1(5, pe);
    e = pe + 1;
    while (cyc < e + 7) tick();
`ifdef FIR_FEEDER_ZERO_FILL_EN
    expect_issue(11, e + 16);
`else
    expect_issue(11, e + 9);
`endif
    push1(11, pe2);
    chk("slot_push_edge", pe2, e + 8);
    drain(40);

    // 4: single sample then silence
    do_reset();
    u0 = n_under;
    expect_issue(7, cyc + 2);
    push1(7, pe);
    while (cyc < pe + 28) tick();
    chk("queue_after_single", exp_q.size(), 0);
`ifdef FIR_FEEDER_ZERO_FILL_EN
    chk("underrun_count", n_under - u0, 3);
`else
    chk("underrun_count", n_under - u0, 0);
`endif

    // 5: async reset mid-GAP with a backlog
    do_reset();
    expect_issue(1, cyc + 2);
    for (int i = 1; i <= 7; i++) push1(i, pe);
    e0 = pe - 6;
    while (cyc < e0 + 9) tick();
    chk("pre_reset_fir_en", 32'(fir_en), 1);
    chk("pre_reset_level", 32'(level), 5);
    rst_n = 1'b0;
    #1;
    chk("async_reset_fir_en", 32'(fir_en), 0);
    chk("async_reset_level", 32'(level), 0);
    chk("async_reset_s_ready", 32'(s_if.s_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    last_en = -1000;
    tick();
    expect_issue(42, cyc + 2);
    push1(42, pe2);
    drain(20);
    repeat (20) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
